// File: rtl/sr_muldiv.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, fixed latency of WIDTH+1 edges.
// start/busy/valid handshake; kill aborts the current operation without a result.
module sr_muldiv #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             kill,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    state_t               state, state_next;
    logic [2:0]           op_q;
    logic                 neg_a, neg_b, b_zero;
    logic [WIDTH-1:0]     opnd;       // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   acc;        // {partial product | remainder, multiplier | quotient}
    logic [CNT_W-1:0]     count;

    logic                 accept;
    logic                 a_signed, b_signed, neg_a_in, neg_b_in;
    logic [WIDTH-1:0]     mag_a_in, mag_b_in;
    logic [WIDTH:0]       add_sum, rem_shift, trial;
    logic                 q_bit;
    logic [2*WIDTH-1:0]   mul_next, div_next, prod_s;
    logic [WIDTH-1:0]     quo_s, rem_s, sel;

    assign busy   = (state != IDLE);
    assign accept = (state == IDLE) && start && !kill;

    // Operand sign handling at the accept edge.
    always_comb begin
        a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        neg_a_in = a_signed && srcA[WIDTH-1];
        neg_b_in = b_signed && srcB[WIDTH-1];
        mag_a_in = neg_a_in ? -srcA : srcA;
        mag_b_in = neg_b_in ? -srcB : srcB;
    end

    // One shift-add multiply step and one restoring divide step.
    always_comb begin
        add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next  = {add_sum, acc[WIDTH-1:1]};
        rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        trial     = rem_shift - {1'b0, opnd};
        q_bit     = !trial[WIDTH];
        div_next  = {(q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0]),
                     acc[WIDTH-2:0], q_bit};
    end

    // Sign fix-up and output select; divide-by-zero keeps the all-ones quotient.
    always_comb begin
        prod_s = (neg_a ^ neg_b) ? -acc : acc;
        quo_s  = ((neg_a ^ neg_b) && !b_zero) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_s  = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (!op_q[2])
            sel = (op_q == OP_MUL) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
        else
            sel = op_q[1] ? rem_s : quo_s;
    end

    // NOTE: every signal written in always_comb is given a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CALC;
            CALC:    if (kill) state_next = IDLE;
                     else if (count == CNT_W'(1)) state_next = SIGN;
            SIGN:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            b_zero <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            count  <= '0;
            valid  <= 1'b0;
            result <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    op_q   <= op;
                    neg_a  <= neg_a_in;
                    neg_b  <= neg_b_in;
                    b_zero <= (srcB == '0);
                    opnd   <= op[2] ? mag_b_in : mag_a_in;
                    acc    <= {{WIDTH{1'b0}}, (op[2] ? mag_a_in : mag_b_in)};
                    count  <= CNT_W'(WIDTH);
                end
                CALC: begin
                    count <= count - CNT_W'(1);
                    acc   <= op_q[2] ? div_next : mul_next;
                end
                SIGN: if (!kill) begin
                    result <= sel;
                    valid  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sr_muldiv.sv
// Scoreboard bench for sr_muldiv: stimulus pushes model results, a negedge monitor pops on valid.
module tb_sr_muldiv;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         kill = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] srcA = '0;
    logic [W-1:0] srcB = '0;
    logic         busy, valid;
    logic [W-1:0] result;

    sr_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .kill(kill), .op(op),
        .srcA(srcA), .srcB(srcB), .busy(busy), .valid(valid), .result(result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        int           cyc;
    } exp_t;
    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;
    logic [W-1:0] last_res = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: RV32M semantics from 64-bit integer arithmetic.
    function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        logic [63:0] p;
        case (o)
            3'd0: begin p = 64'(ua * ub); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin if (b == 0) return '1; p = 64'(sa / sb); return p[31:0]; end
            3'd5: begin if (b == 0) return '1; return a / b; end
            3'd6: begin if (b == 0) return a;  p = 64'(sa % sb); return p[31:0]; end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    // Monitor: every valid must match the oldest outstanding expectation, on time.
    always @(negedge clk) begin
        if (valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 64'(valid), 64'(0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", 64'(result), 64'(e.res));
                check("latency", 64'(cyc), 64'(e.cyc));
                last_res = e.res;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        if (busy) check("idle_timeout", 64'(busy), 64'(0));
    endtask

    // Presents one request for exactly one edge, then scrambles operands.
    task automatic start_raw(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_it);
        wait_idle();
        op = o; srcA = a; srcB = b; start = 1'b1;
        if (expect_it) sb_q.push_back('{model(o, a, b), cyc + W + 2});
        step();
        start = 1'b0;
        op = 3'($urandom); srcA = $urandom; srcB = $urandom;
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start_raw(o, a, b, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            step();
            n++;
        end
        check("drain_empty", 64'(sb_q.size()), 64'(0));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 7));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not terminate (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_valid", 64'(valid), 64'(0));
        check("reset_result", 64'(result), 64'(0));
        step(); step();
        rst_n = 1'b1;
        step();

        // Reset in the middle of a calculation.
        start_raw(3'd0, 32'd9, 32'd9, 1'b0);
        repeat (9) step();
        rst_n = 1'b0;
        #1;
        check("midreset_busy", 64'(busy), 64'(0));
        check("midreset_valid", 64'(valid), 64'(0));
        check("midreset_result", 64'(result), 64'(0));
        last_res = '0;
        step();
        rst_n = 1'b1;
        step();
        issue(3'd0, 32'd3, 32'd4);

        // Directed vectors, issued back-to-back.
        issue(3'd0, 32'd7, 32'hFFFF_FFFD);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2);
        issue(3'd5, 32'hFFFF_FFF9, 32'd2);
        issue(3'd7, 32'hFFFF_FFF9, 32'd2);
        issue(3'd5, 32'd5, 32'd0);
        issue(3'd7, 32'd5, 32'd0);
        issue(3'd4, 32'h8000_0000, 32'd0);
        issue(3'd6, 32'h8000_0000, 32'd0);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        drain();

        // start held high through the whole operation: one op only.
        op = 3'd3; srcA = 32'h1234_5678; srcB = 32'h9ABC_DEF0; start = 1'b1;
        sb_q.push_back('{model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0), cyc + W + 2});
        repeat (W + 2) step();
        start = 1'b0;
        repeat (40) step();
        check("held_start_drained", 64'(sb_q.size()), 64'(0));

        // kill ten cycles after start.
        start_raw(3'd4, 32'd1000, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        #1 kill = 1'b1;
        step();
        check("kill_busy", 64'(busy), 64'(0));
        kill = 1'b0;
        repeat (40) step();
        check("kill_result_held", 64'(result), 64'(last_res));

        // start and kill together in IDLE.
        op = 3'd0; srcA = 32'd5; srcB = 32'd5; start = 1'b1; kill = 1'b1;
        step();
        check("startkill_busy", 64'(busy), 64'(0));
        start = 1'b0; kill = 1'b0;

        // kill during the SIGN cycle.
        start_raw(3'd0, 32'd11, 32'd13, 1'b0);
        repeat (W) @(posedge clk);
        #1;
        check("sign_busy_before", 64'(busy), 64'(1));
        kill = 1'b1;
        step();
        check("signkill_valid", 64'(valid), 64'(0));
        check("signkill_busy", 64'(busy), 64'(0));
        kill = 1'b0;
        repeat (3) step();
        check("signkill_result_held", 64'(result), 64'(last_res));

        // New start accepted after the kills.
        issue(3'd1, 32'hFFFF_FFFE, 32'd3);

        // Randomised back-to-back traffic.
        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick());
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
